// File: rtl/router_ingress_fifo_if.sv
// Ingress FIFO bundle: upstream push side and
// router-facing head/status side.
interface router_ingress_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] in_data;
  logic [1:0]            in_addr;
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            dest_ready;
  logic [DATA_WIDTH-1:0] din;
  logic [1:0]            addr;
  logic                  din_en;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic [15:0]           stall_cnt;

  modport master (
    output in_data, in_addr, in_valid, dest_ready,
    input  in_ready, din, addr, din_en,
    input  count, full, empty, stall_cnt
  );

  modport slave (
    input  in_data, in_addr, in_valid, dest_ready,
    output in_ready, din, addr, din_en,
    output count, full, empty, stall_cnt
  );
endinterface

// File: rtl/router_ingress_fifo.sv
// In-order ingress buffer ahead of the 4-way router;
// head is offered only when its destination is ready.
module router_ingress_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic                 clk,
  input logic                 resetn,
  router_ingress_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [1:0]            mem_addr [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [15:0]   stall;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic [1:0] hd_addr;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign hd_addr = empty ? 2'd0 : mem_addr[rd_ptr];
  assign pop     = !empty && bus.dest_ready[hd_addr];
  assign push    = bus.in_valid && !full;

  assign bus.in_ready  = !full;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = cnt;
  assign bus.din_en    = pop;
  assign bus.addr      = hd_addr;
  assign bus.din       = empty ? '0 : mem_data[rd_ptr];
  assign bus.stall_cnt = stall;

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= bus.in_data;
      mem_addr[wr_ptr] <= bus.in_addr;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Saturating head-of-line stall counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall <= '0;
    else if (!empty && !pop && stall != 16'hFFFF)
      stall <= stall + 16'd1;
  end
endmodule

// File: tb/tb_router_ingress_fifo.sv
// Directed bench for router_ingress_fifo:
// handshake, HOL blocking, wrap, saturation, async reset.
module tb_router_ingress_fifo;
  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  router_ingress_fifo_if #(
    .DATA_WIDTH(32), .DEPTH(4)
  ) bus ();

  router_ingress_fifo #(
    .DATA_WIDTH(32), .DEPTH(4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic        v,
    input logic [31:0] d,
    input logic [1:0]  a
  );
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_addr  = a;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    resetn = 1'b0;
    drive(1'b0, 32'h0, 2'd0);
    bus.dest_ready = 4'hF;
    #12 resetn = 1'b1;
    tick();

    // reset / idle
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_din_en", 32'(bus.din_en), 0);
    chk("rst_din", bus.din, 0);
    chk("rst_addr", 32'(bus.addr), 0);
    chk("rst_stall", 32'(bus.stall_cnt), 0);

    // single word, one-cycle latency
    bus.dest_ready = 4'b0100;
    drive(1'b1, 32'hA5A5_0001, 2'd2);
    #1;
    chk("one_no_bypass", 32'(bus.din_en), 0);
    tick();
    drive(1'b0, 32'h0, 2'd0);
    #1;
    chk("one_din", bus.din, 32'hA5A5_0001);
    chk("one_addr", 32'(bus.addr), 2);
    chk("one_din_en", 32'(bus.din_en), 1);
    chk("one_count", 32'(bus.count), 1);
    tick();
    chk("one_empty", 32'(bus.empty), 1);
    chk("one_count0", 32'(bus.count), 0);
    chk("one_din_en0", 32'(bus.din_en), 0);

    // fill to full with all ports blocked
    bus.dest_ready = 4'h0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hD000_0000 + 32'(i), 2'(i));
      tick();
    end
    chk("full_count", 32'(bus.count), 4);
    chk("full_flag", 32'(bus.full), 1);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    chk("full_stall", 32'(bus.stall_cnt), 3);
    drive(1'b1, 32'hEEEE_EEEE, 2'd1);
    tick();
    drive(1'b0, 32'h0, 2'd0);
    chk("full_reject", 32'(bus.count), 4);
    chk("full_stall2", 32'(bus.stall_cnt), 4);
    chk("full_head", bus.din, 32'hD000_0000);
    bus.dest_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_en", 32'(bus.din_en), 1);
      chk("drain_din", bus.din, 32'hD000_0000 + 32'(i));
      chk("drain_addr", 32'(bus.addr), 32'(i));
      tick();
    end
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_stall", 32'(bus.stall_cnt), 4);

    // head-of-line blocking
    bus.dest_ready = 4'b1101;
    drive(1'b1, 32'hB000_0001, 2'd1);
    tick();
    drive(1'b1, 32'hB000_0002, 2'd0);
    tick();
    drive(1'b0, 32'h0, 2'd0);
    #1;
    chk("hol_en", 32'(bus.din_en), 0);
    chk("hol_din", bus.din, 32'hB000_0001);
    tick();
    chk("hol_count", 32'(bus.count), 2);
    chk("hol_stall", 32'(bus.stall_cnt), 6);
    bus.dest_ready = 4'hF;
    #1;
    chk("hol_en1", 32'(bus.din_en), 1);
    chk("hol_d1", bus.din, 32'hB000_0001);
    tick();
    chk("hol_en2", 32'(bus.din_en), 1);
    chk("hol_d2", bus.din, 32'hB000_0002);
    chk("hol_a2", 32'(bus.addr), 0);
    tick();
    chk("hol_empty", 32'(bus.empty), 1);

    // simultaneous push/pop across pointer wrap
    bus.dest_ready = 4'h0;
    drive(1'b1, 32'hC000_0000, 2'd3);
    tick();
    drive(1'b1, 32'hC000_0001, 2'd3);
    tick();
    chk("pp_stall", 32'(bus.stall_cnt), 7);
    bus.dest_ready = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'hC000_0002 + 32'(k), 2'd3);
      #1;
      chk("pp_en", 32'(bus.din_en), 1);
      chk("pp_din", bus.din, 32'hC000_0000 + 32'(k));
      tick();
      chk("pp_count", 32'(bus.count), 2);
    end
    drive(1'b0, 32'h0, 2'd0);
    #1;
    chk("pp_tail0", bus.din, 32'hC000_0006);
    tick();
    chk("pp_tail1", bus.din, 32'hC000_0007);
    tick();
    chk("pp_empty", 32'(bus.empty), 1);
    chk("pp_stall2", 32'(bus.stall_cnt), 7);

    // stall saturation then async reset
    bus.dest_ready = 4'h0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hF000_0000 + 32'(i), 2'd1);
      tick();
    end
    drive(1'b0, 32'h0, 2'd0);
    chk("sat_stall9", 32'(bus.stall_cnt), 9);
    repeat (65540) tick();
    chk("sat_max", 32'(bus.stall_cnt), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(bus.stall_cnt), 32'hFFFF);
    chk("sat_count", 32'(bus.count), 3);
    bus.dest_ready = 4'b0010;
    #1;
    chk("ar_pre_en", 32'(bus.din_en), 1);
    resetn = 1'b0;
    #1;
    chk("ar_count", 32'(bus.count), 0);
    chk("ar_din_en", 32'(bus.din_en), 0);
    chk("ar_stall", 32'(bus.stall_cnt), 0);
    chk("ar_empty", 32'(bus.empty), 1);
    chk("ar_din", bus.din, 0);
    tick();
    resetn = 1'b1;
    tick();
    chk("ar_after", 32'(bus.count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/router_ingress_fifo.md
Name: router_ingress_fifo

Overview:
Ingress buffer sitting directly upstream of the simple 4-way router. Accepts (data, destination address) pairs over a valid/ready handshake and stores them in order in a DEPTH-entry FIFO. Presents the head entry to the router as din/addr/din_en only when the addressed destination signals ready. Counts head-of-line stall cycles for debug.

Parameters:
DATA_WIDTH, 32, width of payload word; matches the router data width.
DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
resetn  input  1  asynchronous active-low reset.
in_data  input  DATA_WIDTH  payload from upstream.
in_addr  input  2  destination port 0..3 for in_data.
in_valid  input  1  upstream offers in_data/in_addr this cycle.
in_ready  output  1  FIFO can accept this cycle.
dest_ready  input  4  bit i high = router output i's consumer can take a word this cycle.
din  output  DATA_WIDTH  head payload to router.
addr  output  2  head destination to router.
din_en  output  1  head word is transferred to router this cycle.
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
stall_cnt  output  16  saturating count of head-of-line stall cycles.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): read/write pointers = 0, count = 0, stall_cnt = 0. Outputs: in_ready = 1, full = 0, empty = 1, din_en = 0, din = 0, addr = 0. Memory array is not reset.
- Push: occurs when in_valid && in_ready. The entry is written at wr_ptr and wr_ptr advances modulo DEPTH.
- in_ready = !full. in_ready is a function of registered state only, with no combinational path from dest_ready or in_valid. A push into a full FIFO is never accepted, even if a pop occurs in the same cycle.
- Head visibility: a word pushed in cycle N appears on din/addr in cycle N+1 at the earliest (1-cycle latency through an empty FIFO; no bypass).
- din_en = !empty && dest_ready[head_addr]. This path is combinational from dest_ready.
- din and addr = head entry when !empty. When empty, both are forced to 0.
- Pop: occurs when din_en = 1. rd_ptr advances modulo DEPTH.
- Strict in-order delivery. Head-of-line blocking is intended; entries behind a blocked head wait.
- Occupancy update:
  - push only: count +1.
  - pop only: count -1.
  - push and pop in the same cycle (possible only when !full and !empty): count unchanged, both pointers advance.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0. Full/empty are derived from count, not from pointer equality.
- stall_cnt increments by 1 each cycle where !empty && !dest_ready[head_addr]. It saturates at 16'hFFFF and clears only on reset.
- dest_ready bits for ports other than head_addr have no effect.
- Reset mid-operation: all buffered entries are discarded and din_en drops immediately, since the reset is asynchronous.
- No X propagation: din/addr must never expose uninitialised memory. This is guaranteed by the empty gating.

Test Plan:
- Reset then idle, dest_ready=4'hF -> in_ready=1, empty=1, count=0, din_en=0, din=0, addr=0, stall_cnt=0.
- Push (0xA5A5_0001, addr 2) in cycle 0 with dest_ready=4'b0100 -> cycle 1: din=0xA5A5_0001, addr=2, din_en=1; cycle 2: empty=1, count=0.
- Push 4 words (addr 0,1,2,3) with dest_ready=0 -> full=1, in_ready=0, count=4. A 5th in_valid is not accepted. stall_cnt increments 1 per cycle while the head is blocked. Then set dest_ready=4'hF -> 4 consecutive din_en pulses in push order, addr 0,1,2,3.
- Head addr 1 blocked (dest_ready=4'b1101), second entry addr 0 -> din_en stays 0 and the second entry is not delivered (HOL blocking). Raise bit 1 -> both delivered in order on consecutive cycles.
- count=2, simultaneous push and pop for 6 cycles -> count stays 2, data stays in order, and pointers wrap past DEPTH-1 without loss or duplication.
- Force stall_cnt near saturation (hold the head blocked for 65540 cycles) -> stall_cnt = 16'hFFFF and holds. Assert resetn=0 mid-stream with count=3 -> count=0, din_en=0, stall_cnt=0 immediately, without waiting for a clock edge.
